// File: rtl/exec_md_ctrl.sv
// exec_md_ctrl: R-type ALU control decode plus a bit-serial multiply/divide
// sequencer that owns the architectural HI/LO registers.
module exec_md_ctrl #(
    parameter int WIDTH = 32,
    parameter int FN_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       op,
    input  logic [FN_W-1:0]  fn,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic [3:0]       aluc,
    output logic [1:0]       sel_hilo,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [3:0] ALU_ADD = 4'd1, ALU_ADDU = 4'd2, ALU_SUB = 4'd3, ALU_SUBU = 4'd4,
                           ALU_AND = 4'd5, ALU_OR = 4'd6, ALU_XOR = 4'd7, ALU_NOR = 4'd8,
                           ALU_SLT = 4'd9, ALU_SLTU = 4'd10, ALU_SLL = 4'd11, ALU_SRL = 4'd12,
                           ALU_SRA = 4'd13;
    localparam logic [FN_W-1:0] FN_MFHI = FN_W'('h10), FN_MTHI = FN_W'('h11),
                                FN_MFLO = FN_W'('h12), FN_MTLO = FN_W'('h13);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state, w_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_b, r_rs, r_hi, r_lo;
    logic               r_div, r_neg_q, r_neg_r, r_dz, r_done;
    logic               w_rtype, w_md_op, w_hi_op, w_free, w_acc, w_mt, w_sa, w_sb, w_fin;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q, w_r;
    logic [WIDTH:0]     w_mul_sum, w_div_sh, w_div_df;
    logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_prod;

    assign w_rtype = op == 4'hf;
    assign w_md_op = fn == FN_W'('h18) || fn == FN_W'('h19) || fn == FN_W'('h1a) || fn == FN_W'('h1b);
    assign w_hi_op = fn == FN_MFHI || fn == FN_MTHI || fn == FN_MFLO || fn == FN_MTLO;
    assign w_free  = in_valid & !flush & !md_busy & w_rtype;
    assign w_acc   = w_free & w_md_op;
    assign w_mt    = w_free & (fn == FN_MTHI || fn == FN_MTLO);
    assign w_fin   = r_state == S_FIX && !flush;

    assign md_busy  = r_state != S_IDLE;
    assign md_done  = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stall    = in_valid & md_busy & w_rtype & (w_md_op | w_hi_op);
    assign sel_hilo = !w_rtype ? 2'd0 : fn == FN_MFHI ? 2'd1 : fn == FN_MFLO ? 2'd2 : 2'd0;

    always_comb begin
        aluc = op;
        if (w_rtype) begin
            case (fn)
                FN_W'('h20):              aluc = ALU_ADD;
                FN_W'('h21):              aluc = ALU_ADDU;
                FN_W'('h22):              aluc = ALU_SUB;
                FN_W'('h23):              aluc = ALU_SUBU;
                FN_W'('h24):              aluc = ALU_AND;
                FN_W'('h25):              aluc = ALU_OR;
                FN_W'('h26):              aluc = ALU_XOR;
                FN_W'('h27):              aluc = ALU_NOR;
                FN_W'('h2a):              aluc = ALU_SLT;
                FN_W'('h2b):              aluc = ALU_SLTU;
                FN_W'('h00), FN_W'('h04): aluc = ALU_SLL;
                FN_W'('h02), FN_W'('h06): aluc = ALU_SRL;
                FN_W'('h03), FN_W'('h07): aluc = ALU_SRA;
                default:                  aluc = 4'h0;
            endcase
        end
    end

    // MULT/DIV have fn[0] clear; their operands run as magnitudes
    assign w_sa    = !fn[0] & rs_val[WIDTH-1];
    assign w_sb    = !fn[0] & rt_val[WIDTH-1];
    assign w_abs_a = w_sa ? -rs_val : rs_val;
    assign w_abs_b = w_sb ? -rt_val : rt_val;

    assign w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_mul_sum, r_p[WIDTH-1:1]};
    assign w_div_sh  = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_div_df  = w_div_sh - {1'b0, r_b};
    assign w_div_nxt = {w_div_df[WIDTH] ? w_div_sh[WIDTH-1:0] : w_div_df[WIDTH-1:0],
                        r_p[WIDTH-2:0], !w_div_df[WIDTH]};

    assign w_prod = r_neg_q ? -r_p : r_p;
    assign w_q    = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_r    = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  w_nxt = w_acc ? S_RUN : S_IDLE;
            S_RUN:   w_nxt = flush ? S_IDLE : r_cnt == '0 ? S_FIX : S_RUN;
            S_FIX:   w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_p     <= '0;
            r_b     <= '0;
            r_rs    <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_acc) begin
                r_cnt   <= CW'(WIDTH - 1);
                r_p     <= {{WIDTH{1'b0}}, w_abs_a};
                r_b     <= w_abs_b;
                r_rs    <= rs_val;
                r_div   <= fn[1];
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_dz    <= rt_val == '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
                r_p   <= r_div ? w_div_nxt : w_mul_nxt;
            end
            if (w_fin) begin
                r_hi <= !r_div ? w_prod[2*WIDTH-1:WIDTH] : r_dz ? r_rs : w_r;
                r_lo <= !r_div ? w_prod[WIDTH-1:0] : r_dz ? {WIDTH{1'b1}} : w_q;
            end else if (w_mt) begin
                if (fn == FN_MTHI) r_hi <= rs_val;
                else r_lo <= rs_val;
            end
        end
    end
endmodule
